jpeg_stream_stuffer: RTL and testbench

JPEG_STREAM_STUFFER -- requirements
Module: jpeg_stream_stuffer

---
 rtl/jpeg_stream_pkg.sv | 18 +
 rtl/jpeg_word_fifo.sv | 49 ++++
 rtl/jpeg_stream_stuffer.sv | 129 ++++++++++++
 tb/tb_jpeg_stream_stuffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_stream_pkg.sv
// Shared FSM encoding and JPEG marker constants for the scan-byte stuffer.
`timescale 1ns/1ps
package jpeg_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BYTE,
    ST_STUFF,
    ST_EOI_FF,
    ST_EOI_D9
  } state_e;

  localparam logic [7:0] MARKER_PFX = 8'hFF;
  localparam logic [7:0] MARKER_EOI = 8'hD9;
  localparam logic [7:0] STUFF_BYTE = 8'h00;

endpackage

// File: rtl/jpeg_word_fifo.sv
// Synchronous word FIFO; a push while full is accepted only when a pop happens in the same cycle.
`timescale 1ns/1ps
module jpeg_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/jpeg_stream_stuffer.sv
// Serialises entropy-coded words into JPEG scan bytes with 0xFF stuffing and an EOI trailer.
`timescale 1ns/1ps
module jpeg_stream_stuffer
  import jpeg_stream_pkg::*;
#(
  parameter int unsigned PIC_ENC_IN_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH       = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [PIC_ENC_IN_WIDTH-1:0] pic_encode_seq_i,
  input  logic                        pic_encode_valid_i,
  input  logic                        pic_frame_end_i,
  output logic [7:0]                  byte_o,
  output logic                        byte_valid_o,
  input  logic                        byte_ready_i,
  output logic                        done_o,
  output logic                        overflow_o
);

  localparam int unsigned NB = PIC_ENC_IN_WIDTH / 8;
  localparam int unsigned CW = $clog2(NB + 1);

  state_e                      state_q, state_d;
  logic [PIC_ENC_IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        end_q, end_d;
  logic                        done_q, done_d;
  logic                        ovf_q, ovf_d;

  logic [PIC_ENC_IN_WIDTH-1:0] fifo_data;
  logic                        fifo_full, fifo_empty, fifo_drop, fifo_pop;
  logic [7:0]                  cur_byte;
  state_e                      after_word;

  jpeg_word_fifo #(
    .WIDTH (PIC_ENC_IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (pic_encode_valid_i),
    .data_i  (pic_encode_seq_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign cur_byte   = shreg_q[PIC_ENC_IN_WIDTH-1 -: 8];
  assign after_word = fifo_empty ? ST_IDLE : ST_LOAD;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    end_d        = end_q | pic_frame_end_i;
    done_d       = 1'b0;
    ovf_d        = ovf_q | fifo_drop;
    fifo_pop     = 1'b0;
    byte_o       = '0;
    byte_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
        else if (end_q)  state_d = ST_EOI_FF;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        shreg_d  = fifo_data;
        cnt_d    = '0;
        state_d  = ST_BYTE;
      end
      ST_BYTE: begin
        byte_valid_o = 1'b1;
        byte_o       = cur_byte;
        if (byte_ready_i) begin
          shreg_d = shreg_q << 8;
          cnt_d   = cnt_q + 1'b1;
          // A stuffed 0xFF finishes its word from STUFF, which sees the advanced count.
          if (cur_byte == MARKER_PFX)      state_d = ST_STUFF;
          else if (cnt_q == CW'(NB - 1))   state_d = after_word;
        end
      end
      ST_STUFF: begin
        byte_valid_o = 1'b1;
        byte_o       = STUFF_BYTE;
        if (byte_ready_i) state_d = (cnt_q == CW'(NB)) ? after_word : ST_BYTE;
      end
      ST_EOI_FF: begin
        byte_valid_o = 1'b1;
        byte_o       = MARKER_PFX;
        if (byte_ready_i) state_d = ST_EOI_D9;
      end
      ST_EOI_D9: begin
        byte_valid_o = 1'b1;
        byte_o       = MARKER_EOI;
        if (byte_ready_i) begin
          done_d  = 1'b1;
          end_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_jpeg_stream_stuffer.sv
// Directed bench for jpeg_stream_stuffer: stuffing, backpressure, EOI, overflow and reset.
`timescale 1ns/1ps
module tb_jpeg_stream_stuffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seq;
  logic        vld, fend, ready;
  logic [7:0]  byte_o;
  logic        byte_valid, done, ovf;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  logic [7:0]  bytes_q[$];
  int          cyc_q[$];

  always #5 clk = ~clk;

  jpeg_stream_stuffer #(
    .PIC_ENC_IN_WIDTH (32),
    .FIFO_DEPTH       (8)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .pic_encode_seq_i   (seq),
    .pic_encode_valid_i (vld),
    .pic_frame_end_i    (fend),
    .byte_o             (byte_o),
    .byte_valid_o       (byte_valid),
    .byte_ready_i       (ready),
    .done_o             (done),
    .overflow_o         (ovf)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (byte_valid && ready) begin
      bytes_q.push_back(byte_o);
      cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_word(input logic [31:0] w, input logic fe);
    @(posedge clk); #1;
    seq = w; vld = 1'b1; fend = fe;
    @(posedge clk); #1;
    vld = 1'b0; fend = 1'b0;
  endtask

  task automatic clear_q();
    bytes_q.delete();
    cyc_q.delete();
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k = 0;
    while (bytes_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, bytes_q.size(), n);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!byte_valid && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, {31'd0, byte_valid}, 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      logic [31:0] got;
      got = (i < bytes_q.size()) ? {24'd0, bytes_q[i]} : 32'hDEAD_BEEF;
      check($sformatf("%s[%0d]", tag, i), got, {24'd0, exp[i]});
    end
    repeat (6) @(negedge clk);
    #1;
    check({tag, "_count"}, bytes_q.size(), exp.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e[$];
    int lat;
    rst_n = 1'b0; seq = '0; vld = 1'b0; fend = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte",  {24'd0, byte_o},     32'd0);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_ovf",   {31'd0, ovf},        32'd0);
    rst_n = 1'b1;

    // 12FF3400: stuffing after FF, consecutive transfers, first-byte latency
    ready = 1'b1;
    clear_q();
    push_word(32'h12FF3400, 1'b0);
    lat = 0;
    while (!byte_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    wait_bytes("w1_wait", 5, 30);
    for (int i = 1; i < 5; i++)
      if (i < cyc_q.size()) check($sformatf("w1_consec%0d", i), cyc_q[i] - cyc_q[0], i);
    e = {8'h12, 8'hFF, 8'h00, 8'h34, 8'h00};
    check_seq("w1", e);

    // all-FF word
    clear_q();
    push_word(32'hFFFFFFFF, 1'b0);
    wait_bytes("w2_wait", 8, 40);
    e = {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    check_seq("w2", e);

    // backpressure while B2 is presented
    @(posedge clk); #1 ready = 1'b0;
    clear_q();
    push_word(32'hA1B2C3D4, 1'b0);
    wait_valid("w3_valid");
    check("w3_first", {24'd0, byte_o}, 32'hA1);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("w3_hold_byte%0d", i),  {24'd0, byte_o},     32'hB2);
      check($sformatf("w3_hold_valid%0d", i), {31'd0, byte_valid}, 32'd1);
    end
    @(posedge clk); #1 ready = 1'b1;
    wait_bytes("w3_wait", 4, 30);
    e = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_seq("w3", e);

    // frame end in the same cycle as the last word
    clear_q();
    done_cnt = 0;
    push_word(32'hAABBCCDD, 1'b1);
    wait_bytes("w4_wait", 6, 40);
    e = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hD9};
    check_seq("w4", e);
    check("w4_done_cnt", done_cnt, 1);
    if (cyc_q.size() >= 6) check("w4_done_cyc", done_cyc, cyc_q[5] + 1);
    check("w4_ovf", {31'd0, ovf}, 32'd0);

    // ten words into a stalled sink: the tenth is dropped
    @(posedge clk); #1 ready = 1'b0;
    clear_q();
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      seq = 32'(i); vld = 1'b1;
      if (i == 10) check("ovf_before10", {31'd0, ovf}, 32'd0);
    end
    @(posedge clk); #1 vld = 1'b0;
    check("ovf_after10", {31'd0, ovf}, 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    wait_bytes("ovf_wait", 36, 200);
    e = {};
    for (int i = 1; i <= 9; i++) begin
      e.push_back(8'h00); e.push_back(8'h00); e.push_back(8'h00); e.push_back(8'(i));
    end
    check_seq("ovf_words", e);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // asynchronous reset mid-word
    @(posedge clk); #1 ready = 1'b0;
    clear_q();
    push_word(32'hDEADBEEF, 1'b0);
    wait_valid("mid_valid");
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    check("mid_rst_byte",  {24'd0, byte_o},     32'd0);
    check("mid_rst_ovf",   {31'd0, ovf},        32'd0);
    check("mid_rst_done",  {31'd0, done},       32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_q();
    ready = 1'b1;
    push_word(32'h01020304, 1'b0);
    wait_bytes("post_wait", 4, 30);
    e = {8'h01, 8'h02, 8'h03, 8'h04};
    check_seq("post_rst", e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
